// File: rtl/alu_arbiter_seq_if.sv
// alu_arbiter_seq_if: requester, ALU and response bundle for alu_arbiter_seq
interface alu_arbiter_seq_if #(
    parameter int n  = 4,
    parameter int CW = 8
);
    logic          req0_valid, req0_ready;
    logic [n-1:0]  req0_A, req0_B;
    logic [2:0]    req0_mode;
    logic          req1_valid, req1_ready;
    logic [n-1:0]  req1_A, req1_B;
    logic [2:0]    req1_mode;
    logic [n-1:0]  alu_A, alu_B, alu_result;
    logic [2:0]    alu_mode;
    logic          alu_carry_borrow;
    logic          resp_valid, resp_ready, resp_id, resp_carry;
    logic [n-1:0]  resp_result;
    logic [CW-1:0] op_count;
    modport slave (
        input  req0_valid, req0_A, req0_B, req0_mode,
        input  req1_valid, req1_A, req1_B, req1_mode,
        input  alu_result, alu_carry_borrow, resp_ready,
        output req0_ready, req1_ready, alu_A, alu_B, alu_mode,
        output resp_valid, resp_id, resp_result, resp_carry, op_count
    );
    modport master (
        output req0_valid, req0_A, req0_B, req0_mode,
        output req1_valid, req1_A, req1_B, req1_mode,
        output alu_result, alu_carry_borrow, resp_ready,
        input  req0_ready, req1_ready, alu_A, alu_B, alu_mode,
        input  resp_valid, resp_id, resp_result, resp_carry, op_count
    );
endinterface

// File: rtl/alu_arbiter_seq.sv
// alu_arbiter_seq: round-robin sharing of one external combinational ALU between two requesters
module alu_arbiter_seq #(
    parameter int n  = 4,
    parameter int CW = 8
) (
    input logic              clk,
    input logic              rst,
    alu_arbiter_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t        r_state, w_next;
    logic          r_last, r_valid, r_id, r_carry;
    logic [n-1:0]  r_alu_a, r_alu_b, r_result;
    logic [2:0]    r_mode;
    logic [CW-1:0] r_count;
    logic          w_idle, w_rdy0, w_rdy1, w_hs0, w_hs1;
    // On a tie exactly one ready is high, so at most one handshake per cycle
    always_comb begin
        w_idle = r_state == IDLE;
        w_rdy0 = w_idle & (!bus.req1_valid | r_last);
        w_rdy1 = w_idle & (!bus.req0_valid | !r_last);
        w_hs0  = bus.req0_valid & w_rdy0;
        w_hs1  = bus.req1_valid & w_rdy1 & !w_hs0;
        w_next = w_idle ? ((w_hs0 | w_hs1) ? EXEC : IDLE) :
                 r_state == EXEC ? RESP : (bus.resp_ready ? IDLE : RESP);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_last   <= 1'b1;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_mode   <= '0;
            r_id     <= 1'b0;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state <= w_next;
            if (w_hs0 | w_hs1) begin
                r_alu_a <= w_hs1 ? bus.req1_A : bus.req0_A;
                r_alu_b <= w_hs1 ? bus.req1_B : bus.req0_B;
                r_mode  <= w_hs1 ? bus.req1_mode : bus.req0_mode;
                r_id    <= w_hs1;
                r_last  <= w_hs1;
            end
            if (r_state == EXEC) begin
                r_result <= bus.alu_result;
                r_carry  <= bus.alu_carry_borrow;
                r_valid  <= 1'b1;
            end
            if (r_state == RESP && bus.resp_ready) begin
                r_valid <= 1'b0;
                r_count <= r_count + {{(CW-1){1'b0}}, ~&r_count};
            end
        end
    end
    assign bus.req0_ready  = w_rdy0;
    assign bus.req1_ready  = w_rdy1;
    assign bus.alu_A       = r_alu_a;
    assign bus.alu_B       = r_alu_b;
    assign bus.alu_mode    = r_mode;
    assign bus.resp_valid  = r_valid;
    assign bus.resp_id     = r_id;
    assign bus.resp_result = r_result;
    assign bus.resp_carry  = r_carry;
    assign bus.op_count    = r_count;
endmodule

// File: tb/tb_alu_arbiter_seq.sv
// tb_alu_arbiter_seq: scoreboard bench for alu_arbiter_seq with a behavioural ALU attached
module tb_alu_arbiter_seq;
    localparam int N = 4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   fails = 0;

    alu_arbiter_seq_if #(.n(N), .CW(8)) bus ();
    alu_arbiter_seq_if #(.n(N), .CW(2)) bus2 ();
    alu_arbiter_seq #(.n(N), .CW(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    alu_arbiter_seq #(.n(N), .CW(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    always #5 clk = ~clk;

    function automatic logic [N:0] alu_f(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] m);
        case (m)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {a < b, a - b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {1'b0, ~a};
            3'd6:    return {a[N-1], a << 1};
            default: return {a[0], a >> 1};
        endcase
    endfunction

    assign {bus.alu_carry_borrow, bus.alu_result}   = alu_f(bus.alu_A, bus.alu_B, bus.alu_mode);
    assign {bus2.alu_carry_borrow, bus2.alu_result} = alu_f(bus2.alu_A, bus2.alu_B, bus2.alu_mode);
    assign bus2.req0_valid = bus.req0_valid;
    assign bus2.req0_A     = bus.req0_A;
    assign bus2.req0_B     = bus.req0_B;
    assign bus2.req0_mode  = bus.req0_mode;
    assign bus2.req1_valid = bus.req1_valid;
    assign bus2.req1_A     = bus.req1_A;
    assign bus2.req1_B     = bus.req1_B;
    assign bus2.req1_mode  = bus.req1_mode;
    assign bus2.resp_ready = bus.resp_ready;

    typedef struct {
        logic         id;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [2:0]   m;
    } op_t;
    op_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Predictor: decides from the arbitration rules who is accepted and when a response is due
    logic m_busy, m_last, pe0, pe1, pid;
    int   m_age;
    always @(negedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_last = 1'b1;
            m_age  = 0;
            q.delete();
        end else if (!m_busy) begin
            pe0 = !bus.req1_valid | m_last;
            pe1 = !bus.req0_valid | !m_last;
            chk("ready_idle", {bus.req0_ready, bus.req1_ready}, {pe0, pe1});
            chk("resp_valid_idle", bus.resp_valid, 0);
            if ((bus.req0_valid & pe0) | (bus.req1_valid & pe1)) begin
                pid = !(bus.req0_valid & pe0);
                q.push_back('{pid, pid ? bus.req1_A : bus.req0_A, pid ? bus.req1_B : bus.req0_B,
                              pid ? bus.req1_mode : bus.req0_mode});
                m_last = pid;
                m_busy = 1'b1;
                m_age  = 0;
            end
        end else begin
            m_age++;
            chk("ready_busy", {bus.req0_ready, bus.req1_ready}, 0);
            chk("resp_valid_timing", bus.resp_valid, m_age >= 2);
            if (m_age >= 2 && bus.resp_ready) m_busy = 1'b0;
        end
    end

    // Monitor: checks every presented response against the queued expectation
    int           m_cnt;
    logic         hold;
    logic [N+2:0] held;
    op_t          mop;
    always @(negedge clk) begin
        if (rst) begin
            m_cnt = 0;
            hold  = 1'b0;
            chk("reset_outputs", {bus.alu_A, bus.alu_B, bus.alu_mode, bus.resp_valid, bus.resp_id,
                                  bus.resp_result, bus.resp_carry}, 0);
            chk("reset_count", bus.op_count, 0);
            chk("reset_count_cw2", bus2.op_count, 0);
        end else begin
            chk("op_count", bus.op_count, m_cnt);
            chk("op_count_cw2", bus2.op_count, m_cnt > 3 ? 3 : m_cnt);
            if (hold) chk("resp_stable", {bus.resp_valid, bus.resp_id, bus.resp_result, bus.resp_carry}, held);
            if (bus.resp_valid) begin
                chk("queue_depth", q.size(), 1);
                if (q.size() > 0) begin
                    mop = q[0];
                    chk("alu_operands", {bus.alu_A, bus.alu_B, bus.alu_mode}, {mop.a, mop.b, mop.m});
                    chk("resp_id", bus.resp_id, mop.id);
                    chk("resp_data", {bus.resp_carry, bus.resp_result}, alu_f(mop.a, mop.b, mop.m));
                    if (bus.resp_ready) begin
                        void'(q.pop_front());
                        m_cnt++;
                    end
                end
            end
            hold = bus.resp_valid & !bus.resp_ready;
            held = {bus.resp_valid, bus.resp_id, bus.resp_result, bus.resp_carry};
        end
    end

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic v0, input logic [N-1:0] a0, input logic [N-1:0] b0, input logic [2:0] m0,
                         input logic v1, input logic [N-1:0] a1, input logic [N-1:0] b1, input logic [2:0] m1);
        bus.req0_valid = v0;
        bus.req0_A     = a0;
        bus.req0_B     = b0;
        bus.req0_mode  = m0;
        bus.req1_valid = v1;
        bus.req1_A     = a1;
        bus.req1_B     = b1;
        bus.req1_mode  = m1;
    endtask

    initial begin
        rst = 1'b1;
        bus.resp_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(2);
        rst = 1'b0;
        cyc(2);
        drive(1, 4'b0101, 4'b0011, 3'd0, 0, 0, 0, 0);
        cyc(1);
        drive(0, 4'hA, 4'hA, 3'd7, 0, 0, 0, 0);
        cyc(4);
        drive(1, 4'b1111, 4'b0001, 3'd0, 1, 4'b1001, 4'b0111, 3'd0);
        cyc(12);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(2);
        bus.resp_ready = 1'b0;
        drive(0, 0, 0, 0, 1, 4'h6, 4'h9, 3'd1);
        cyc(1);
        drive(0, 0, 0, 0, 0, 4'h1, 4'h1, 3'd2);
        cyc(7);
        bus.resp_ready = 1'b1;
        cyc(2);
        drive(1, 4'h3, 4'h4, 3'd4, 1, 4'hC, 4'h5, 3'd3);
        cyc(1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(3);
        bus.resp_ready = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        bus.resp_ready = 1'b1;
        cyc(6);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(1);
        for (int i = 0; i < 5; i++) begin
            drive(1, 4'($urandom), 4'($urandom), 3'($urandom), 0, 0, 0, 0);
            cyc(3);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(3);
        repeat (400) begin
            drive(1'($urandom), 4'($urandom), 4'($urandom), 3'($urandom),
                  1'($urandom), 4'($urandom), 4'($urandom), 3'($urandom));
            bus.resp_ready = $urandom_range(0, 3) != 0;
            cyc(1);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        bus.resp_ready = 1'b1;
        cyc(5);
        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
